// File: rtl/chan_acq_sequencer.sv
// Channel acquisition sequencer: accepts a trigger, delays it, fans it out to a
// snapshot of enabled channels, collects done flags (optional timeout) and emits one event word.
//
// state | meaning
// IDLE  | waiting for trigger, acq_ready high
// DELAY | counting trigger delay before fan-out
// FILL  | acq_trig asserted, waiting for enabled dones or timeout
// STORE | event word presented to FIFO until accepted
module chan_acq_sequencer #(
  parameter int NUM_CHAN = 5,
  parameter int TYPE_W   = 2,
  parameter int TNUM_W   = 24,
  parameter int DELAY_W  = 32,
  parameter int TMO_W    = 24,
  localparam int FIFO_W  = 1 + 2*NUM_CHAN + TYPE_W + TNUM_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CHAN-1:0]        chan_en,
  input  logic [DELAY_W-1:0]         trig_delay,
  input  logic [TMO_W-1:0]           acq_timeout,
  input  logic                       trigger,
  input  logic [TYPE_W-1:0]          trig_type,
  input  logic [TNUM_W-1:0]          trig_num,
  output logic                       acq_ready,
  input  logic [NUM_CHAN-1:0]        acq_dones,
  output logic [NUM_CHAN*TYPE_W-1:0] acq_enable,
  output logic [NUM_CHAN-1:0]        acq_trig,
  input  logic                       fifo_ready,
  output logic                       fifo_valid,
  output logic [FIFO_W-1:0]          fifo_data,
  output logic [1:0]                 state,
  output logic [15:0]                missed_trig_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_FILL  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [TNUM_W-1:0]   num_q, num_d;
  logic [NUM_CHAN-1:0] en_q, en_d;
  logic [NUM_CHAN-1:0] done_q, done_d;
  logic                flag_q, flag_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [DELAY_W-1:0]  dcnt_q, dcnt_d;
  logic [TMO_W-1:0]    fcnt_q, fcnt_d;
  logic [15:0]         missed_q, missed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      type_q   <= '0;
      num_q    <= '0;
      en_q     <= '0;
      done_q   <= '0;
      flag_q   <= 1'b0;
      delay_q  <= '0;
      dcnt_q   <= '0;
      fcnt_q   <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      num_q    <= num_d;
      en_q     <= en_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
      delay_q  <= delay_d;
      dcnt_q   <= dcnt_d;
      fcnt_q   <= fcnt_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    num_d    = num_q;
    en_d     = en_q;
    done_d   = done_q;
    flag_d   = flag_q;
    delay_d  = delay_q;
    dcnt_d   = dcnt_q;
    fcnt_d   = fcnt_q;
    missed_d = missed_q;

    if (trigger && state_q != S_IDLE && missed_q != 16'hFFFF)
      missed_d = missed_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          type_d  = trig_type;
          num_d   = trig_num;
          en_d    = chan_en;
          delay_d = trig_delay;
          done_d  = '0;
          flag_d  = 1'b0;
          dcnt_d  = '0;
          fcnt_d  = '0;
          if (chan_en == '0)
            state_d = S_STORE;
          else if (trig_delay == '0)
            state_d = S_FILL;
          else
            state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        // delay_q is nonzero here, so delay_q-1 cannot wrap
        if (dcnt_q == delay_q - DELAY_W'(1)) begin
          state_d = S_FILL;
          fcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DELAY_W'(1);
        end
      end
      S_FILL: begin
        if ((acq_dones & en_q) == en_q) begin
          state_d = S_STORE;
          done_d  = acq_dones & en_q;
          flag_d  = 1'b0;
        end else if (acq_timeout != '0 && fcnt_q == acq_timeout - TMO_W'(1)) begin
          state_d = S_STORE;
          done_d  = acq_dones & en_q;
          flag_d  = 1'b1;
        end else begin
          fcnt_d = fcnt_q + TMO_W'(1);
        end
      end
      S_STORE: begin
        if (fifo_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acq_enable = '0;
    for (int i = 0; i < NUM_CHAN; i++)
      if (state_q == S_FILL && en_q[i])
        acq_enable[i*TYPE_W +: TYPE_W] = type_q;
  end

  assign acq_trig        = (state_q == S_FILL) ? en_q : '0;
  assign acq_ready       = (state_q == S_IDLE);
  assign fifo_valid      = (state_q == S_STORE);
  assign fifo_data       = fifo_valid ? {flag_q, en_q, done_q, type_q, num_q} : '0;
  assign state           = state_q;
  assign missed_trig_cnt = missed_q;

endmodule

// File: tb/tb_chan_acq_sequencer.sv
// Directed bench for chan_acq_sequencer: expected event words are queued when a
// trigger is driven and compared when the sequencer presents them.
module tb_chan_acq_sequencer;
  localparam int FW = 37;

  logic           clk = 1'b0;
  logic           reset;
  logic [4:0]     chan_en;
  logic [31:0]    trig_delay;
  logic [23:0]    acq_timeout;
  logic           trigger;
  logic [1:0]     trig_type;
  logic [23:0]    trig_num;
  logic           acq_ready;
  logic [4:0]     acq_dones;
  logic [9:0]     acq_enable;
  logic [4:0]     acq_trig;
  logic           fifo_ready;
  logic           fifo_valid;
  logic [FW-1:0]  fifo_data;
  logic [1:0]     state;
  logic [15:0]    missed_trig_cnt;

  int tests = 0;
  int fails = 0;
  logic [FW-1:0] exp_q[$];

  chan_acq_sequencer dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .trig_delay(trig_delay),
    .acq_timeout(acq_timeout), .trigger(trigger), .trig_type(trig_type),
    .trig_num(trig_num), .acq_ready(acq_ready), .acq_dones(acq_dones),
    .acq_enable(acq_enable), .acq_trig(acq_trig), .fifo_ready(fifo_ready),
    .fifo_valid(fifo_valid), .fifo_data(fifo_data), .state(state),
    .missed_trig_cnt(missed_trig_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] word(logic flag, logic [4:0] en, logic [4:0] dn,
                                         logic [1:0] ty, logic [23:0] num);
    return {flag, en, dn, ty, num};
  endfunction

  // Drive one trigger pulse; it is sampled at the next edge.
  task automatic fire(logic [4:0] en, logic [31:0] d, logic [1:0] ty, logic [23:0] num);
    chan_en = en; trig_delay = d; trig_type = ty; trig_num = num; trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic expect_word(string tag);
    int n = 0;
    logic [FW-1:0] e = '1;
    while (!fifo_valid && n < 200) begin tick(); n++; end
    check({tag, "_valid"}, 64'(fifo_valid), 64'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, "_data"}, 64'(fifo_data), 64'(e));
    tick();
    check({tag, "_idle"}, 64'(state), 64'd0);
    check({tag, "_vlow"}, 64'(fifo_valid), 64'd0);
    check({tag, "_dzero"}, 64'(fifo_data), 64'd0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_ready"}, 64'(acq_ready), 64'd1);
    check({tag, "_trig"}, 64'(acq_trig), 64'd0);
    check({tag, "_enable"}, 64'(acq_enable), 64'd0);
    check({tag, "_valid"}, 64'(fifo_valid), 64'd0);
    check({tag, "_data"}, 64'(fifo_data), 64'd0);
    check({tag, "_missed"}, 64'(missed_trig_cnt), 64'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; chan_en = '0; trig_delay = '0; acq_timeout = '0; trigger = 1'b0;
    trig_type = '0; trig_num = '0; acq_dones = '0; fifo_ready = 1'b1;
    tick(); tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Basic event, D=0, dones arrive in the fourth FILL cycle
    exp_q.push_back(word(1'b0, 5'b10101, 5'b10101, 2'd2, 24'h123456));
    fire(5'b10101, 32'd0, 2'd2, 24'h123456);
    for (int i = 0; i < 4; i++) begin
      check("basic_state", 64'(state), 64'd2);
      check("basic_trig", 64'(acq_trig), 64'b10101);
      check("basic_enable", 64'(acq_enable), 64'b10_00_10_00_10);
      if (i == 3) acq_dones = 5'b11111;
      tick();
    end
    check("basic_store", 64'(state), 64'd3);
    check("basic_trig_off", 64'(acq_trig), 64'd0);
    expect_word("basic");
    acq_dones = '0;

    // Delay D=7 and D=1: cycles from trigger edge to acq_trig
    acq_dones = 5'b11111;
    exp_q.push_back(word(1'b0, 5'b00110, 5'b00110, 2'd1, 24'h000007));
    fire(5'b00110, 32'd7, 2'd1, 24'h000007);
    check("d7_state", 64'(state), 64'd1);
    cnt = 1;
    while (acq_trig == '0 && cnt < 50) begin tick(); cnt++; end
    check("d7_latency", 64'(cnt), 64'd8);
    expect_word("d7");
    exp_q.push_back(word(1'b0, 5'b11000, 5'b11000, 2'd3, 24'h000001));
    fire(5'b11000, 32'd1, 2'd3, 24'h000001);
    cnt = 1;
    while (acq_trig == '0 && cnt < 50) begin tick(); cnt++; end
    check("d1_latency", 64'(cnt), 64'd2);
    expect_word("d1");

    // Timeout after 10 FILL cycles with only channel 0 done
    acq_dones = 5'b00001; acq_timeout = 24'd10;
    exp_q.push_back(word(1'b1, 5'b10001, 5'b00001, 2'd0, 24'hABCDEF));
    fire(5'b10001, 32'd0, 2'd0, 24'hABCDEF);
    cnt = 0;
    while (state == 2'd2 && cnt < 100) begin tick(); cnt++; end
    check("tmo_fill_cycles", 64'(cnt), 64'd10);
    expect_word("tmo");

    // Timeout disabled: FILL holds until the last done
    acq_timeout = 24'd0;
    exp_q.push_back(word(1'b0, 5'b10001, 5'b10001, 2'd1, 24'h00BEEF));
    fire(5'b10001, 32'd0, 2'd1, 24'h00BEEF);
    repeat (30) tick();
    check("notmo_hold", 64'(state), 64'd2);
    acq_dones = 5'b10001;
    tick();
    check("notmo_store", 64'(state), 64'd3);
    expect_word("notmo");

    // Done and timeout in the same cycle: done wins
    acq_dones = '0; acq_timeout = 24'd3;
    exp_q.push_back(word(1'b0, 5'b00010, 5'b00010, 2'd3, 24'h000333));
    fire(5'b00010, 32'd0, 2'd3, 24'h000333);
    tick(); tick();
    acq_dones = 5'b00010;
    tick();
    expect_word("tie");
    acq_dones = '0; acq_timeout = 24'd0;

    // Backpressure with three missed triggers and input changes after acceptance
    fifo_ready = 1'b0;
    exp_q.push_back(word(1'b0, 5'b01111, 5'b01111, 2'd2, 24'h000055));
    fire(5'b01111, 32'd3, 2'd2, 24'h000055);
    chan_en = 5'b11111; trig_type = 2'd1; trig_delay = 32'd0; trig_num = 24'h999999;
    pulse();
    tick(); tick();
    check("bp_fill", 64'(state), 64'd2);
    pulse();
    check("bp_enable_snap", 64'(acq_enable), 64'b00_10_10_10_10);
    acq_dones = 5'b01111;
    tick();
    pulse();
    for (int i = 0; i < 20; i++) begin
      check("bp_data_stable", 64'(fifo_data), 64'(exp_q[0]));
      check("bp_ready_low", 64'(acq_ready), 64'd0);
      tick();
    end
    fifo_ready = 1'b1;
    expect_word("bp");
    check("bp_missed", 64'(missed_trig_cnt), 64'd3);
    acq_dones = '0;

    // Empty mask goes straight to STORE
    exp_q.push_back(word(1'b0, 5'b00000, 5'b00000, 2'd1, 24'h0000E0));
    fire(5'b00000, 32'd5, 2'd1, 24'h0000E0);
    check("empty_state", 64'(state), 64'd3);
    check("empty_trig", 64'(acq_trig), 64'd0);
    expect_word("empty");

    // Reset mid-FILL discards the event and clears the missed count
    fire(5'b00011, 32'd0, 2'd2, 24'h0000AA);
    tick();
    check("rstfill_state", 64'(state), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("rstfill");
    cnt = 0;
    repeat (5) begin tick(); if (fifo_valid) cnt++; end
    check("rstfill_noword", 64'(cnt), 64'd0);
    acq_dones = 5'b00001;
    exp_q.push_back(word(1'b0, 5'b00001, 5'b00001, 2'd3, 24'h0000BB));
    fire(5'b00001, 32'd2, 2'd3, 24'h0000BB);
    expect_word("after_rst");
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
